// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared constants, FSM encoding and AES byte-level helpers for the
// reverse-order AES-128 key schedule.
package aes_inv_key_schedule_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX_FLAT[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  // Round constant used when deriving the words of the previous round.
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] aes_sub_word(input logic [31:0] x);
    return {aes_sbox(x[31:24]), aes_sbox(x[23:16]), aes_sbox(x[15:8]), aes_sbox(x[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key handshake bundle between the key setup logic, the reverse key
// schedule and the inverse-cipher round controller.
interface aes_inv_key_schedule_if;
  import aes_inv_key_schedule_pkg::*;

  logic        start;
  logic [31:0] last_word_1;
  logic [31:0] last_word_2;
  logic [31:0] last_word_3;
  logic [31:0] last_word_4;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_word_1;
  logic [31:0] o_word_2;
  logic [31:0] o_word_3;
  logic [31:0] o_word_4;
  logic [3:0]  o_round;
  logic        o_busy;
  logic        o_done;

  // Side that loads the last key and consumes round keys.
  modport master (
    output start, last_word_1, last_word_2, last_word_3, last_word_4, i_ready,
    input  o_valid, o_word_1, o_word_2, o_word_3, o_word_4, o_round, o_busy, o_done
  );

  // Side that produces round keys (the key schedule itself).
  modport slave (
    input  start, last_word_1, last_word_2, last_word_3, last_word_4, i_ready,
    output o_valid, o_word_1, o_word_2, o_word_3, o_word_4, o_round, o_busy, o_done
  );

endinterface

// File: rtl/aes_inv_key_schedule_step.sv
// One backwards step of the AES-128 key expansion: given the four words of
// round r, produce the four words of round r-1. Pure combinational.
module aes_inv_key_schedule_step
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  input  logic [31:0] w3,
  input  logic [3:0]  round,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);

  logic [31:0] rot_p3;

  // Words 1..3 of the previous round fall out of neighbouring XORs; word 0
  // needs the recovered last word of that round pushed through RotWord,
  // SubWord and the round constant of the current round.
  always_comb begin
    p3     = w3 ^ w2;
    p2     = w2 ^ w1;
    p1     = w1 ^ w0;
    rot_p3 = {p3[23:0], p3[31:24]};
    p0     = w0 ^ aes_sub_word(rot_p3) ^ {aes_rcon(round), 24'h000000};
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse-order AES-128 round-key generator. Loads the round-10 key and
// walks the schedule back to round 0, one key per accepted beat.
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int ROUNDS = AES_NR
) (
  input  logic                   clk,
  input  logic                   areset,
  aes_inv_key_schedule_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic        load_key;
  logic        step_key;
  logic        finish;
  logic [31:0] w0_q;
  logic [31:0] w1_q;
  logic [31:0] w2_q;
  logic [31:0] w3_q;
  logic [3:0]  round_q;
  logic        done_q;
  logic [31:0] p0;
  logic [31:0] p1;
  logic [31:0] p2;
  logic [31:0] p3;

  aes_inv_key_schedule_step u_step (
    .w0    (w0_q),
    .w1    (w1_q),
    .w2    (w2_q),
    .w3    (w3_q),
    .round (round_q),
    .p0    (p0),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3)
  );

  // State register; reset abandons any walk in progress.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and datapath controls; start only counts while idle, so a
  // start coinciding with the round-0 acceptance is dropped.
  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    step_key   = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_EMIT;
          load_key   = 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.i_ready) begin
          if (round_q == 4'd0) begin
            state_next = ST_IDLE;
            finish     = 1'b1;
          end else begin
            step_key = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Key and round registers; the round-0 key stays visible after the walk.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (load_key) begin
        w0_q    <= bus.last_word_1;
        w1_q    <= bus.last_word_2;
        w2_q    <= bus.last_word_3;
        w3_q    <= bus.last_word_4;
        round_q <= 4'(ROUNDS);
      end else if (step_key) begin
        w0_q    <= p0;
        w1_q    <= p1;
        w2_q    <= p2;
        w3_q    <= p3;
        round_q <= round_q - 4'd1;
      end
    end
  end

  assign bus.o_valid  = (state == ST_EMIT);
  assign bus.o_busy   = (state == ST_EMIT);
  assign bus.o_done   = done_q;
  assign bus.o_word_1 = w0_q;
  assign bus.o_word_2 = w1_q;
  assign bus.o_word_3 = w2_q;
  assign bus.o_word_4 = w3_q;
  assign bus.o_round  = round_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for the reverse AES-128 key schedule. Expected keys
// come from a forward key expansion built on an S-box derived from GF(2^8)
// arithmetic, queued when a start is accepted and compared as keys emerge.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic areset;

  always #5 clk = ~clk;

  aes_inv_key_schedule_if bus ();

  aes_inv_key_schedule #(.ROUNDS(10)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int cmp_count = 0;
  int mis_count = 0;
  int cycle_cnt = 0;
  int done_cnt = 0;
  int start_cycle = 0;
  int done_cycle = 0;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  bit hold_low = 1'b0;
  bit rand_ready = 1'b0;

  logic [131:0] exp_q[$];
  logic [131:0] stim_exp[0:10];
  logic [131:0] cap_r10;
  logic [131:0] cap_r9;
  logic [131:0] cap_r0;
  logic [7:0]   sbox_ref[0:255];
  logic [7:0]   rcon_ref[1:10];
  logic [31:0]  fw[0:43];

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      mis_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxRef(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Forward AES-128 key expansion of a cipher key into fw[0..43].
  task automatic expandKey(input logic [127:0] key0);
    logic [31:0] t;
    fw[0] = key0[127:96];
    fw[1] = key0[95:64];
    fw[2] = key0[63:32];
    fw[3] = key0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = fw[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]} ^
            {rcon_ref[i/4], 24'h000000};
      end
      fw[i] = fw[i-4] ^ t;
    end
  endtask

  task automatic pulseStart(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.last_word_1 = a;
    bus.last_word_2 = b;
    bus.last_word_3 = c;
    bus.last_word_4 = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Prepare the expected key sequence for a cipher key and launch a walk.
  task automatic applyStimulus(input logic [127:0] key0);
    expandKey(key0);
    for (int r = 0; r <= 10; r++)
      stim_exp[r] = {4'(r), fw[4*r], fw[4*r+1], fw[4*r+2], fw[4*r+3]};
    pulseStart(fw[40], fw[41], fw[42], fw[43]);
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt != d0);
    checkOutput("walk_done", 132'(ok), 132'(1));
  endtask

  task automatic waitRound(input logic [3:0] rnd, input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1 && bus.o_round === rnd) found = 1'b1;
    end
    checkOutput("reach_round", 132'(found), 132'(1));
  endtask

  // Consumer ready: held high, randomised, or forced low for backpressure.
  always @(posedge clk) begin
    #1;
    if (hold_low)        bus.i_ready = 1'b0;
    else if (rand_ready) bus.i_ready = ($urandom_range(0, 9) < 7);
    else                 bus.i_ready = 1'b1;
  end

  // Scoreboard monitor: one look per cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [131:0] cur;
    bit next_busy;
    bit next_done;
    if (areset) begin
      exp_q.delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      cycle_cnt++;
      checkOutput("valid", 132'(bus.o_valid), 132'(exp_busy));
      checkOutput("busy", 132'(bus.o_busy), 132'(exp_busy));
      checkOutput("done", 132'(bus.o_done), 132'(exp_done));
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        done_cycle = cycle_cnt;
      end
      next_busy = exp_busy;
      next_done = 1'b0;
      if (exp_busy) begin
        if (exp_q.size() == 0) begin
          checkOutput("queue_underrun", 132'(exp_q.size()), 132'(1));
        end else begin
          cur = {bus.o_round, bus.o_word_1, bus.o_word_2, bus.o_word_3, bus.o_word_4};
          checkOutput("key", cur, exp_q[0]);
          if (bus.i_ready === 1'b1) begin
            if (exp_q[0][131:128] == 4'd10) cap_r10 = cur;
            if (exp_q[0][131:128] == 4'd9)  cap_r9 = cur;
            if (exp_q[0][131:128] == 4'd0) begin
              cap_r0 = cur;
              next_busy = 1'b0;
              next_done = 1'b1;
            end
            void'(exp_q.pop_front());
          end
        end
      end else if (bus.start === 1'b1) begin
        for (int r = 10; r >= 0; r--) exp_q.push_back(stim_exp[r]);
        next_busy = 1'b1;
        start_cycle = cycle_cnt;
      end
      exp_busy = next_busy;
      exp_done = next_done;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    logic [127:0] key;
    rcon_ref[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rcon_ref[j] = xtime(rcon_ref[j-1]);
    for (int x = 0; x < 256; x++) sbox_ref[x] = sboxRef(8'(x));

    areset = 1'b1;
    bus.start = 1'b0;
    bus.last_word_1 = '0;
    bus.last_word_2 = '0;
    bus.last_word_3 = '0;
    bus.last_word_4 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", 132'({bus.o_valid, bus.o_busy, bus.o_done, bus.o_round}), 132'(0));
    checkOutput("reset_words", 132'({bus.o_word_1, bus.o_word_2, bus.o_word_3, bus.o_word_4}), 132'(0));
    @(posedge clk);
    #1;
    areset = 1'b0;

    $display("[TB] FIPS-197 A.1 walk");
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
    waitDone(100, ok);
    checkOutput("fips_r10", cap_r10, {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    checkOutput("fips_r9", cap_r9, {4'd9, 128'hac7766f319fadc2128d12941575c006e});
    checkOutput("fips_r0", cap_r0, {4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    checkOutput("done_latency", 132'(done_cycle - start_cycle), 132'(12));
    checkOutput("hold_r0", 132'({bus.o_word_1, bus.o_word_2, bus.o_word_3, bus.o_word_4}),
                132'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    checkOutput("queue_empty", 132'(exp_q.size()), 132'(0));

    $display("[TB] backpressure at round 7");
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    waitRound(4'd8, 50);
    hold_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold", {bus.o_round, bus.o_word_1, bus.o_word_2, bus.o_word_3, bus.o_word_4},
                  stim_exp[7]);
      checkOutput("bp_valid", 132'(bus.o_valid), 132'(1));
    end
    hold_low = 1'b0;
    waitDone(100, ok);
    checkOutput("queue_empty", 132'(exp_q.size()), 132'(0));

    $display("[TB] start while walking");
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    waitRound(4'd5, 50);
    pulseStart($urandom, $urandom, $urandom, $urandom);
    waitDone(100, ok);
    checkOutput("queue_empty", 132'(exp_q.size()), 132'(0));

    $display("[TB] reset mid-walk");
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    waitRound(4'd6, 50);
    @(posedge clk);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("mid_reset_ctrl", 132'({bus.o_valid, bus.o_busy, bus.o_done, bus.o_round}), 132'(0));
    checkOutput("mid_reset_words", 132'({bus.o_word_1, bus.o_word_2, bus.o_word_3, bus.o_word_4}), 132'(0));
    @(posedge clk);
    #1;
    areset = 1'b0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    waitDone(100, ok);
    checkOutput("queue_empty", 132'(exp_q.size()), 132'(0));

    $display("[TB] random keys with random ready");
    rand_ready = 1'b1;
    for (int run = 0; run < 1000; run++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(key);
      waitDone(400, ok);
      if (!ok) break;
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 132'(exp_q.size()), 132'(0));
    checkOutput("total_dones", 132'(done_cnt), 132'(1004));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
